mux_stage: RTL and testbench



---
 rtl/mux_stage_pkg.sv | 16 +
 rtl/mux_stage_if.sv | 30 +++
 rtl/mux_pipe_reg.sv | 92 +++++++++
 rtl/mux_stage.sv | 95 +++++++++
 tb/tb_mux_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mux_stage_pkg.sv
// mux_pkg: shared types and constants for the mux_stage selection stage.
//   ERR_CNT_W / ERR_CNT_MAX : width and saturation value of the illegal-select counter
//   mux_word_t              : {data, sel_err} word at the RV32 datapath width. mux_stage
//                             builds the same layout locally at its own WIDTH.
//   pipe_state_e            : occupancy of the skid pipe register
package mux_pkg;
  localparam int         ERR_CNT_W   = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic [31:0] data;
    logic        sel_err;
  } mux_word_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} pipe_state_e;
endpackage

// File: rtl/mux_stage_if.sv
// mux_stage_if: valid/ready bus around a mux_stage.
//   in_valid/in_ready/in_sel/in_data    : upstream offer (in_data[i] is operand i)
//   out_valid/out_ready/out_data/out_sel_err : downstream result
//   master : producer/consumer side (the datapath or a bench)
//   slave  : the stage itself
interface mux_stage_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 3
);
  localparam int SEL_W = $clog2(N_IN);

  logic                        in_valid;
  logic                        in_ready;
  logic [SEL_W-1:0]            in_sel;
  logic [N_IN-1:0][WIDTH-1:0]  in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_sel_err;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel_err
  );
endinterface

// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: storage and handshake for one word type T.
//   clk, rst_n           : clock, async active-low reset (clears held words)
//   in_valid/in_ready    : accept side, in_word captured on in_valid && in_ready
//   out_valid/out_ready  : output side, out_word held stable until taken
// MUX_STAGE_SKID_EN defined  : two entries (main + skid), registered in_ready.
// MUX_STAGE_SKID_EN undefined: one entry, in_ready = !out_valid || out_ready.
module mux_pipe_reg
  import mux_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_word,
  output logic out_valid,
  input  logic out_ready,
  output T     out_word
);
  T main_q, main_d;

`ifdef MUX_STAGE_SKID_EN
  pipe_state_e state_q, state_d;
  T            skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        acc, xfer;

  always_comb begin
    acc     = in_valid && in_ready_q;
    xfer    = (state_q != EMPTY) && out_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (acc) begin main_d = in_word; state_d = ONE; end
      ONE: begin
        if (acc && xfer)  main_d = in_word;
        else if (acc)     begin skid_d = in_word; state_d = TWO; end
        else if (xfer)    state_d = EMPTY;
      end
      // in_ready is low here, so only a transfer can happen
      TWO:     if (xfer) begin main_d = skid_q; state_d = ONE; end
      default: state_d = EMPTY;
    endcase
    // registered ready looks at the next state, so it never depends on out_ready combinationally
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
`else
  logic valid_q, valid_d;
  logic acc;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    acc     = in_valid && in_ready;
    valid_d = acc || (valid_q && !out_ready);
    main_d  = acc ? in_word : main_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else begin
      valid_q <= valid_d;
      main_q  <= main_d;
    end
  end

  assign out_valid = valid_q;
`endif

  assign out_word = main_q;
endmodule

// File: rtl/mux_stage.sv
// mux_stage: registered N_IN-to-1 operand select with valid/ready handshake.
//   clk, rst_n  : clock, async active-low reset
//   bus         : mux_stage_if.slave (in_* offer, out_* result)
//   err_clr     : sync clear of err_sticky / err_count (an illegal accept in the same cycle wins)
//   err_pulse   : registered, high the cycle after an illegal-select accept
//   err_sticky  : set on any illegal accept
//   err_count   : illegal accepts, saturating at 255
// An illegal select (in_sel >= N_IN) captures zero data tagged with sel_err.
// Storage depth is chosen by MUX_STAGE_SKID_EN inside mux_pipe_reg.
module mux_stage
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_stage_if.slave           bus,
  input  logic                 err_clr,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int SEL_W = $clog2(N_IN);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sel_err;
  } word_t;

  word_t                sel_word, out_word;
  logic                 sel_legal;
  logic                 ill_acc;
  logic                 err_pulse_q, err_pulse_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // compare-per-input avoids ever indexing in_data with an out-of-range select
  always_comb begin
    sel_legal = 1'b0;
    sel_word  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (bus.in_sel == SEL_W'(i)) begin
        sel_legal     = 1'b1;
        sel_word.data = bus.in_data[i];
      end
    end
    sel_word.sel_err = !sel_legal;
  end

  mux_pipe_reg #(.T(word_t)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_word   (sel_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_word  (out_word)
  );

  assign bus.out_data    = out_word.data;
  assign bus.out_sel_err = out_word.sel_err;

  always_comb begin
    ill_acc      = bus.in_valid && bus.in_ready && !sel_legal;
    err_pulse_d  = ill_acc;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (ill_acc) begin
      err_sticky_d = 1'b1;
      if (err_clr)                           err_count_d = ERR_CNT_W'(1);
      else if (err_count_q != ERR_CNT_MAX)   err_count_d = err_count_q + ERR_CNT_W'(1);
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
endmodule

// File: tb/tb_mux_stage.sv
// tb_mux_stage: directed vector table plus hand-written sequences for
// backpressure, error saturation/clear and async reset of mux_stage (N_IN=3, WIDTH=32).
module tb_mux_stage;
`ifdef MUX_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic       err_pulse, err_sticky;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  mux_stage_if #(.WIDTH(32), .N_IN(3)) bus ();

  mux_stage #(.WIDTH(32), .N_IN(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_clr    (err_clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] d0, d1, d2;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] w;
    logic        ir;
    int          exp_cnt;

    vecs[0] = '{2'd0, 32'h11,       32'h22,       32'h33,       32'h11,       1'b0};
    vecs[1] = '{2'd1, 32'h11,       32'h22,       32'h33,       32'h22,       1'b0};
    vecs[2] = '{2'd2, 32'h11,       32'h22,       32'h33,       32'h33,       1'b0};
    vecs[3] = '{2'd3, 32'hDEAD,     32'hDEAD,     32'hDEAD,     32'h0,        1'b1};
    vecs[4] = '{2'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{2'd0, 32'h80000001, 32'h0,        32'h1,        32'h80000001, 1'b0};
    vecs[6] = '{2'd1, 32'h0,        32'h12345678, 32'h0,        32'h12345678, 1'b0};
    vecs[7] = '{2'd3, 32'h1,        32'h2,        32'h3,        32'h0,        1'b1};

    rst_n         = 1'b0;
    err_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sel_err", bus.out_sel_err, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back vectors, out_ready=1: each result visible one cycle after accept
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk("vec_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_sel   = vecs[i].sel;
      bus.in_data  = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      @(negedge clk);
      if (vecs[i].exp_err) exp_cnt++;
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_sel_err", i), bus.out_sel_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_err_pulse", i), err_pulse, vecs[i].exp_err);
      chk($sformatf("vec%0d_err_count", i), err_count, exp_cnt);
      chk($sformatf("vec%0d_err_sticky", i), err_sticky, exp_cnt > 0);
    end
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'bxx;
    bus.in_data  = 'x;
    @(negedge clk);
    chk("drain_out_valid", bus.out_valid, 0);
    chk("drain_err_pulse", err_pulse, 0);
    chk("idle_x_count", err_count, 2);

    // saturation at 255
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd3;
    bus.in_data  = '0;
    repeat (300) @(negedge clk);
    chk("sat_count", err_count, 255);
    chk("sat_sticky", err_sticky, 1);
    // clear alone
    bus.in_valid = 1'b0;
    err_clr      = 1'b1;
    @(negedge clk);
    chk("clr_count", err_count, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_pulse", err_pulse, 0);
    // clear together with an illegal accept: event wins
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("clr_ev_count", err_count, 1);
    chk("clr_ev_sticky", err_sticky, 1);
    chk("clr_ev_pulse", err_pulse, 1);
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", err_pulse, 0);
    chk("hold_count", err_count, 1);

    // backpressure: out_ready=0 for 4 cycles with a new word offered each accepted cycle
    bus.out_ready = 1'b0;
    w = 32'h100;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd0;
      bus.in_data  = {32'h0, 32'h0, w};
      ir = bus.in_ready;
      chk($sformatf("bp_in_ready_c%0d", c + 1), ir, c < DEPTH);
      @(negedge clk);
      if (ir) begin q.push_back(w); w = w + 1; end
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_data", bus.out_data, 32'h100);
    end
    bus.in_valid = 1'b0;
    chk("bp_held_words", q.size(), DEPTH);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      if (bus.out_valid) begin
        chk("bp_order", bus.out_data, q[0]);
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_empty", bus.out_valid, 0);

    // async reset while full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd1;
    bus.in_data   = {32'h0, 32'h77, 32'h0};
    repeat (2) @(negedge clk);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_in_ready", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_err_sticky", err_sticky, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_in_ready", bus.in_ready, 1);
    chk("arst_rel_out_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
